ibpl_in6_debounced: RTL

IBPL_IN6_DEBOUNCED -- requirements
Module: ibpl_in6_debounced

---
 rtl/ibpl_pkg.sv | 22 ++
 rtl/ibpl_debounce.sv | 48 ++++
 rtl/ibpl_in6_debounced.sv | 81 ++++++++
 3 files changed

// File: rtl/ibpl_pkg.sv
// Shared constants for the input-only IBPL cardlet: channel counts, the mask of
// channels that exist on the pins, and the activity-LED stretch counter width.
package ibpl_pkg;

    localparam int N_DIOB     = 6;
    localparam int N_INTERNAL = 8;
    localparam int LED_CNT_W  = 24;
    localparam int DEB_CNT_W  = 16;

    localparam logic [N_INTERNAL-1:0] DIOB_CHANNEL_MASK = 8'h3F;

    typedef logic [LED_CNT_W-1:0] led_cnt_t;
    typedef logic [DEB_CNT_W-1:0] deb_cnt_t;

    // True when a slot configuration asks for something this cardlet cannot do:
    // drive a pin, or read a channel that has no pin behind it.
    function automatic logic config_error(input logic [N_INTERNAL-1:0] in_en,
                                          input logic [N_INTERNAL-1:0] out_en);
        return (|(out_en & DIOB_CHANNEL_MASK)) | (|(in_en & ~DIOB_CHANNEL_MASK));
    endfunction

endpackage

// File: rtl/ibpl_debounce.sv
// One pin channel: two-flop synchronizer, persistence counter and accepted level.
// o_accept pulses in the cycle whose rising edge loads a new level into o_stable.
module ibpl_debounce
    import ibpl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_stable,
    output logic o_accept
);

    localparam deb_cnt_t CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic     r_sync1;
    logic     r_sync2;
    logic     r_stable;
    deb_cnt_t r_cnt;
    logic     w_differs;

    assign w_differs = (r_sync2 != r_stable);
    assign o_accept  = w_differs && (r_cnt == CNT_LAST);
    assign o_stable  = r_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            // Any cycle where the synchronized level matches the accepted one restarts the count.
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibpl_in6_debounced.sv
// Six-channel debounced input cardlet: pins are never driven, accepted levels are
// masked by input_enable, and each accepted edge stretches an activity LED.
module ibpl_in6_debounced
    import ibpl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 250,
    parameter int LED_STRETCH_CYCLES = 12_500_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIOB-1:0]     diob_in,
    input  logic [N_INTERNAL-1:0] input_enable,
    input  logic [N_INTERNAL-1:0] output_enable,
    input  logic [N_INTERNAL-1:0] internal_out,
    output logic [N_DIOB-1:0]     diob_dir,
    output logic [N_DIOB-1:0]     diob_out,
    output logic [N_INTERNAL-1:0] internal_in,
    output logic [N_INTERNAL-1:0] diob_led1,
    output logic [N_INTERNAL-1:0] diob_led2,
    output logic                  plugin_error
);

    localparam led_cnt_t STRETCH_LOAD = LED_CNT_W'(LED_STRETCH_CYCLES);
    localparam int       N_SPARE      = N_INTERNAL - N_DIOB;

    logic [N_DIOB-1:0] w_stable;
    logic [N_DIOB-1:0] w_accept;
    logic [N_DIOB-1:0] w_led_active;
    logic [N_DIOB-1:0] w_masked;
    logic              r_plugin_error;
    logic              w_unused;

    generate
        for (genvar gi = 0; gi < N_DIOB; gi++) begin : g_chan
            led_cnt_t r_stretch;

            ibpl_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .i_pin   (diob_in[gi]),
                .o_stable(w_stable[gi]),
                .o_accept(w_accept[gi])
            );

            // A new edge reloads the full on-time rather than adding to what is left.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stretch <= '0;
                end else if (w_accept[gi]) begin
                    r_stretch <= STRETCH_LOAD;
                end else if (r_stretch != '0) begin
                    r_stretch <= r_stretch - 1'b1;
                end
            end

            assign w_led_active[gi] = (r_stretch != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_plugin_error <= 1'b0;
        end else begin
            r_plugin_error <= config_error(input_enable, output_enable);
        end
    end

    assign w_masked     = w_stable & input_enable[N_DIOB-1:0];
    assign diob_dir     = '0;
    assign diob_out     = '0;
    assign internal_in  = {{N_SPARE{1'b0}}, w_masked};
    assign diob_led1    = {{N_SPARE{1'b0}}, w_masked};
    assign diob_led2    = {{N_SPARE{1'b0}}, w_led_active & input_enable[N_DIOB-1:0]};
    assign plugin_error = r_plugin_error;

    // Data toward the cardlet has nowhere to go on an input-only board.
    assign w_unused = ^{internal_out, output_enable[N_INTERNAL-1:N_DIOB]};

endmodule
